imem_responder: RTL and testbench

- Responder end of the instruction-fetch bus: accepts a fetch request (address + syn), returns the instruction word with a one-cycle ack pulse.
- Word-addressed program memory with a configurable number of wait states, so the fetch stage's stall/ack handling can be exercised.
- A load-side write port preloads the program from the testbench or boot logic.
- Sits between the fetch stage and the program store, replacing the ideal zero-latency ROM model.

---
 rtl/imem_responder.sv | 122 ++++++++++++
 tb/tb_imem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-fetch responder: word-addressed program memory with a load-side
// write port, returning one acked word per accepted request after WAIT_CYCLES wait states.
module imem_responder #(
  parameter int                IWIDTH      = 32,
  parameter int                AWIDTH      = 32,
  parameter int                DEPTH       = 1024,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [IWIDTH-1:0] NOP_INSTR   = IWIDTH'(32'h00000013)
) (
  input  logic              m_clk,
  input  logic              m_rst,
  input  logic              m_i_syn,
  input  logic [AWIDTH-1:0] m_i_addr,
  output logic              m_o_ack,
  output logic [IWIDTH-1:0] m_o_instr,
  output logic              m_o_err,
  output logic              m_o_busy,
  input  logic              m_i_we,
  input  logic [AWIDTH-1:0] m_i_waddr,
  input  logic [IWIDTH-1:0] m_i_wdata
);

  localparam int         IDXW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         WIDXW    = AWIDTH - 2;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [IWIDTH-1:0]   instr_q, instr_d;
  logic                err_q, err_d;
  logic [AWIDTH-1:0]   rd_addr;

  logic [IWIDTH-1:0]   mem [DEPTH];

  // Word-aligned and inside the array; shared by the fetch and load paths.
  function automatic logic addr_ok(input logic [AWIDTH-1:0] a);
    return (a[1:0] == 2'b00) && (a[AWIDTH-1:2] < WIDXW'(DEPTH));
  endfunction

  always_ff @(posedge m_clk) begin
    if (m_i_we && addr_ok(m_i_waddr)) begin
      mem[m_i_waddr[IDXW+1:2]] <= m_i_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE, RESP: begin
        if (m_i_syn) begin
          addr_d = m_i_addr;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!m_i_syn) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With no wait states the response is formed on the capture edge itself,
  // so the live address is decoded instead of the latched copy.
  always_comb begin
    rd_addr = (state_q == WAIT) ? addr_q : m_i_addr;
    instr_d = instr_q;
    err_d   = err_q;
    if (state_d == RESP) begin
      if (addr_ok(rd_addr)) begin
        instr_d = mem[rd_addr[IDXW+1:2]];
        err_d   = 1'b0;
      end else begin
        instr_d = NOP_INSTR;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge m_clk or negedge m_rst) begin
    if (!m_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  assign m_o_ack   = (state_q == RESP);
  assign m_o_busy  = (state_q == WAIT);
  assign m_o_instr = instr_q;
  assign m_o_err   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (0 and 3 wait states) share the load port;
// expected responses are queued at issue time and popped by a monitor on each ack.
module tb_imem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] W0    = 32'h00500093;
  localparam logic [31:0] W1    = 32'h00A00113;
  localparam logic [31:0] W2    = 32'h00100193;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        we;
  logic [31:0] waddr, wdata;
  logic        syn0, syn3;
  logic [31:0] addr0, addr3;
  logic        ack0, err0, busy0, ack3, err3, busy3;
  logic [31:0] instr0, instr3;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q0[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  imem_responder #(.IWIDTH(32), .AWIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(0), .NOP_INSTR(NOP)) dut0 (
    .m_clk(clk), .m_rst(rst_n), .m_i_syn(syn0), .m_i_addr(addr0),
    .m_o_ack(ack0), .m_o_instr(instr0), .m_o_err(err0), .m_o_busy(busy0),
    .m_i_we(we), .m_i_waddr(waddr), .m_i_wdata(wdata)
  );

  imem_responder #(.IWIDTH(32), .AWIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(3), .NOP_INSTR(NOP)) dut3 (
    .m_clk(clk), .m_rst(rst_n), .m_i_syn(syn3), .m_i_addr(addr3),
    .m_o_ack(ack3), .m_o_instr(instr3), .m_o_err(err3), .m_o_busy(busy3),
    .m_i_we(we), .m_i_waddr(waddr), .m_i_wdata(wdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : monitor
    exp_t e;
    if (ack0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dut0_unexpected_ack: got ack instr %h, expected no ack", instr0);
      end else begin
        e = q0.pop_front();
        chk("dut0_instr", instr0, e.instr);
        chk1("dut0_err", err0, e.err);
      end
    end
    if (ack3 === 1'b1) begin
      if (q3.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dut3_unexpected_ack: got ack instr %h, expected no ack", instr3);
      end else begin
        e = q3.pop_front();
        chk("dut3_instr", instr3, e.instr);
        chk1("dut3_err", err3, e.err);
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic fetch0(input logic [31:0] a, input logic [31:0] ei, input logic ee);
    syn0 = 1'b1; addr0 = a;
    q0.push_back('{instr: ei, err: ee});
    tick();
    chk1("f0_ack_latency", ack0, 1'b1);
    syn0 = 1'b0;
    tick();
    chk1("f0_ack_pulse", ack0, 1'b0);
  endtask

  task automatic fetch3(input logic [31:0] a, input logic [31:0] ei, input logic ee,
                        input logic [31:0] alt);
    syn3 = 1'b1; addr3 = a;
    q3.push_back('{instr: ei, err: ee});
    tick();
    addr3 = alt;
    for (int k = 0; k < 3; k++) begin
      chk1("f3_busy_wait", busy3, 1'b1);
      chk1("f3_no_early_ack", ack3, 1'b0);
      tick();
    end
    chk1("f3_ack_latency", ack3, 1'b1);
    chk1("f3_busy_resp", busy3, 1'b0);
    syn3 = 1'b0;
    tick();
    chk1("f3_ack_pulse", ack3, 1'b0);
  endtask

  initial begin
    logic [31:0] words [3];
    words[0] = W0; words[1] = W1; words[2] = W2;
    we = 1'b0; waddr = '0; wdata = '0;
    syn0 = 1'b0; syn3 = 1'b0; addr0 = '0; addr3 = '0;

    #1 rst_n = 1'b0;
    #3;
    chk1("rst_ack0", ack0, 1'b0);
    chk1("rst_err0", err0, 1'b0);
    chk1("rst_busy0", busy0, 1'b0);
    chk("rst_instr0", instr0, 32'h0);
    chk1("rst_ack3", ack3, 1'b0);
    chk1("rst_busy3", busy3, 1'b0);
    chk("rst_instr3", instr3, 32'h0);
    @(posedge clk);
    tick();
    rst_n = 1'b1;
    tick();

    wr(32'h0, W0);
    wr(32'h4, W1);
    wr(32'h8, W2);

    fetch0(32'h4, W1, 1'b0);

    // Back-to-back, full throughput
    syn0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr0 = 32'(4 * i);
      q0.push_back('{instr: words[i], err: 1'b0});
      tick();
      chk1("b2b_ack", ack0, 1'b1);
    end
    syn0 = 1'b0;
    tick();
    chk1("b2b_ack_end", ack0, 1'b0);

    fetch3(32'h0, W0, 1'b0, 32'h4);

    // Abandon after one wait cycle
    syn3 = 1'b1; addr3 = 32'h0;
    tick();
    chk1("abandon_busy", busy3, 1'b1);
    tick();
    syn3 = 1'b0;
    tick();
    chk1("abandon_idle", busy3, 1'b0);
    chk1("abandon_no_ack", ack3, 1'b0);
    tick();
    tick();
    fetch3(32'h4, W1, 1'b0, 32'h8);

    fetch0(32'h2, NOP, 1'b1);
    fetch0(32'(4 * DEPTH), NOP, 1'b1);
    fetch3(32'h6, NOP, 1'b1, 32'h0);

    wr(32'(4 * DEPTH), 32'hBAD0BAD0);
    wr(32'h2, 32'hBAD1BAD1);
    fetch0(32'h0, W0, 1'b0);
    fetch0(32'h4, W1, 1'b0);
    fetch0(32'h8, W2, 1'b0);

    // Write lands on the same edge the response is formed
    syn0 = 1'b1; addr0 = 32'h0;
    we = 1'b1; waddr = 32'h0; wdata = 32'hDEADBEEF;
    q0.push_back('{instr: W0, err: 1'b0});
    tick();
    chk1("collide_ack", ack0, 1'b1);
    syn0 = 1'b0; we = 1'b0;
    tick();
    fetch0(32'h0, 32'hDEADBEEF, 1'b0);

    // Reset asserted mid-WAIT
    syn3 = 1'b1; addr3 = 32'h4;
    tick();
    chk1("rstwait_busy", busy3, 1'b1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk1("rstwait_ack", ack3, 1'b0);
    chk1("rstwait_busy_clr", busy3, 1'b0);
    chk("rstwait_instr", instr3, 32'h0);
    syn3 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk1("post_rst_busy", busy3, 1'b0);

    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q3_drained", 32'(q3.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
